// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word in, framed serial out on tx; start bit one cycle after accept.
// Latency: frame is (1+DATA_BITS+parity+STOP_BITS)*CLKS_PER_BIT cycles; ready stays low (backpressure) until the done cycle has passed.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_chk_cpb
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state;
    logic [BW-1:0]          baud;
    logic [IW-1:0]          idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shadow;

    logic                   baud_end;
    logic                   stop_last;
    logic                   par_bit;
    logic [IW-1:0]          idx_next;

    assign baud_end  = (baud == BAUD_LAST);
    assign stop_last = (STOP_BITS == 1) || stop_idx;
    assign par_bit   = (PARITY == 1) ? ~^shadow : ^shadow;
    assign idx_next  = idx + IW'(1);
    assign busy      = ~ready;

    function automatic logic pick(input logic [DATA_BITS-1:0] w, input logic [IW-1:0] i);
        if (LSB_FIRST != 0)
            return w[i];
        else
            return w[IDX_LAST - i];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud     <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            shadow   <= '0;
            tx       <= 1'b1;
            ready    <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        shadow <= data;
                        state  <= START;
                        tx     <= 1'b0;
                        ready  <= 1'b0;
                        baud   <= '0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud  <= '0;
                        idx   <= '0;
                        tx    <= pick(shadow, '0);
                        state <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (idx == IDX_LAST) begin
                            idx <= '0;
                            if (PARITY != 0) begin
                                state <= PAR;
                                tx    <= par_bit;
                            end else begin
                                state    <= STOP;
                                tx       <= 1'b1;
                                stop_idx <= 1'b0;
                            end
                        end else begin
                            idx <= idx_next;
                            tx  <= pick(shadow, idx_next);
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                PAR: begin
                    if (baud_end) begin
                        baud     <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_idx <= 1'b0;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    // done is registered, so raise it one cycle early to land on the final stop cycle
                    if (stop_last && baud == BAUD_PRE)
                        done <= 1'b1;
                    if (baud_end) begin
                        baud <= '0;
                        if (stop_last) begin
                            state    <= IDLE;
                            ready    <= 1'b1;
                            stop_idx <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: five configurations at 4 clocks per bit, per-cycle checks of tx/ready/busy/done.
module tb_uart_tx_param;

    localparam int N   = 5;
    localparam int CPB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_a [N];
    logic [7:0] data_a  [N];
    logic       ready_a [N];
    logic       tx_a    [N];
    logic       busy_a  [N];
    logic       done_a  [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .LSB_FIRST(1)) u_base (
        .clk(clk), .rst_n(rst_n), .valid(valid_a[0]), .data(data_a[0]),
        .ready(ready_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .done(done_a[0]));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .valid(valid_a[1]), .data(data_a[1]),
        .ready(ready_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .done(done_a[1]));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .LSB_FIRST(1)) u_even (
        .clk(clk), .rst_n(rst_n), .valid(valid_a[2]), .data(data_a[2]),
        .ready(ready_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .done(done_a[2]));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .LSB_FIRST(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .valid(valid_a[3]), .data(data_a[3]),
        .ready(ready_a[3]), .tx(tx_a[3]), .busy(busy_a[3]), .done(done_a[3]));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .LSB_FIRST(1)) u_stop2 (
        .clk(clk), .rst_n(rst_n), .valid(valid_a[4]), .data(data_a[4]),
        .ready(ready_a[4]), .tx(tx_a[4]), .busy(busy_a[4]), .done(done_a[4]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp holds the line bits in send order, first bit at exp[nb-1]
    task automatic frame(input int k, input logic [7:0] d, input logic [7:0] d_next,
                         input logic keep, input logic [15:0] exp, input int nb, input string tag);
        int f;
        f = nb * CPB;
        @(negedge clk);
        check({tag, "_idle_ready"}, 32'(ready_a[k]), 32'd1);
        check({tag, "_idle_tx"},    32'(tx_a[k]),    32'd1);
        valid_a[k] = 1'b1;
        data_a[k]  = d;
        @(posedge clk);
        for (int c = 0; c < f; c++) begin
            @(negedge clk);
            check($sformatf("%s_tx_c%0d", tag, c),    32'(tx_a[k]),    32'(exp[nb - 1 - c / CPB]));
            check($sformatf("%s_ready_c%0d", tag, c), 32'(ready_a[k]), 32'd0);
            check($sformatf("%s_busy_c%0d", tag, c),  32'(busy_a[k]),  32'd1);
            check($sformatf("%s_done_c%0d", tag, c),  32'(done_a[k]),  32'(c == f - 1));
            if (c == 0) begin
                valid_a[k] = keep;
                data_a[k]  = d_next;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            valid_a[k] = 1'b0;
            data_a[k]  = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("rst_tx_%0d", k),    32'(tx_a[k]),    32'd1);
            check($sformatf("rst_ready_%0d", k), 32'(ready_a[k]), 32'd1);
            check($sformatf("rst_busy_%0d", k),  32'(busy_a[k]),  32'd0);
            check($sformatf("rst_done_%0d", k),  32'(done_a[k]),  32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        frame(0, 8'hA5, 8'h5A, 1'b0, 16'(10'b0_10100101_1),    10, "lsb_a5");
        frame(1, 8'h0F, 8'hF0, 1'b0, 16'(10'b0_00001111_1),    10, "msb_0f");
        frame(0, 8'h0F, 8'hF0, 1'b0, 16'(10'b0_11110000_1),    10, "lsb_0f");
        frame(2, 8'h07, 8'hF8, 1'b0, 16'(11'b0_11100000_1_1),  11, "even_07");
        frame(3, 8'h07, 8'hF8, 1'b0, 16'(11'b0_11100000_0_1),  11, "odd_07");
        frame(4, 8'hA5, 8'h5A, 1'b0, 16'(11'b0_10100101_1_1),  11, "stop2_a5");

        // back-to-back: valid stays high, data switches to the second word mid-frame
        frame(0, 8'h55, 8'hAA, 1'b1, 16'(10'b0_10101010_1),    10, "b2b_55");
        frame(0, 8'hAA, 8'h00, 1'b0, 16'(10'b0_01010101_1),    10, "b2b_aa");

        // reset in data bit 3 (cycles 16..19 after the start bit begins)
        @(negedge clk);
        valid_a[0] = 1'b1;
        data_a[0]  = 8'hF0;
        @(posedge clk);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) valid_a[0] = 1'b0;
        end
        check("pre_rst_tx", 32'(tx_a[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx",    32'(tx_a[0]),    32'd1);
        check("mid_rst_ready", 32'(ready_a[0]), 32'd1);
        check("mid_rst_busy",  32'(busy_a[0]),  32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("mid_rst_done_%0d", c), 32'(done_a[0]), 32'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post_rst_done_%0d", c), 32'(done_a[0]), 32'd0);
            check($sformatf("post_rst_tx_%0d", c),   32'(tx_a[0]),   32'd1);
        end
        frame(0, 8'hA5, 8'h00, 1'b0, 16'(10'b0_10100101_1), 10, "post_rst_a5");
        @(negedge clk);
        check("final_ready", 32'(ready_a[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 11-bit shift-out transmitter. It adds an internal baud divider, configurable data width, parity mode, stop-bit count and bit order. It uses a valid/ready handshake and reports frame completion. It sits between the lab datapath, which produces words, and the board TX pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (868 = 100 MHz / 115200); legal range >= 2
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; legal values 1 or 2
LSB_FIRST, 1, 1 = payload bit 0 sent first; 0 = MSB sent first

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_n  input  1  asynchronous reset, active-low
valid  input  1  data word available
data  input  DATA_BITS  word to transmit; sampled only on the accept cycle
ready  output  1  block is idle and can accept a word
tx  output  1  serial line, idle high
busy  output  1  a frame is in progress
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: tx=1, ready=1, busy=0, done=0; state=IDLE; baud and bit counters=0; shadow register=0.
- Reset mid-frame: tx forced to 1 immediately (asynchronously). Frame abandoned, no done pulse, block returns to IDLE.
- Accept: a word is accepted on a rising clk edge where valid && ready. data is copied to a shadow register. Parity is computed from the shadow copy. State moves to START.
- Input stability: changes on data or valid after accept are ignored until the next accept.
- States and transitions: IDLE -> START -> DATA -> [PARITY if PARITY != 0] -> STOP -> IDLE.
- Start bit: tx=0 begins on the cycle after accept.
- Bit timing: each bit is held for exactly CLKS_PER_BIT cycles. A baud counter runs 0..CLKS_PER_BIT-1; the bit advances when the counter reaches CLKS_PER_BIT-1.
- DATA state: sends DATA_BITS bits, in order per LSB_FIRST. A bit index counts 0..DATA_BITS-1.
- PARITY state: odd parity means the count of ones in data plus the parity bit is odd; even parity means it is even.
- STOP state: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: F = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles, measured from the first start-bit cycle.
- done: high for exactly one cycle, the last cycle of the final stop bit. The next cycle is IDLE with ready=1.
- busy: busy = !ready. busy is high from the cycle after accept through the done cycle inclusive.
- Back-to-back: with valid held high, the next accept happens on the first IDLE cycle. The next start bit follows one cycle later, giving exactly one extra idle-high cycle between frames.
- tx timing: tx is registered, so there are no glitches and no combinational path from data to tx.
- Illegal parameter values are caught by an elaboration-time check: simulation $error.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit index is $clog2(DATA_BITS) bits. No wrap-around occurs beyond the terminal counts.

Test Plan:
- CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1, LSB_FIRST=1; accept 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. done pulses 40 cycles after the start bit begins; ready=0 throughout the frame.
- Same configuration with LSB_FIRST=0; send 0x0F -> data bits 0,0,0,0,1,1,1,1. The LSB_FIRST=1 case gives 1,1,1,1,0,0,0,0.
- PARITY=2 (even), send 0x07 -> parity bit 1. PARITY=1 (odd), send 0x07 -> parity bit 0. Frame is 44 cycles in both cases.
- STOP_BITS=2, PARITY=0 -> stop high for 8 cycles; frame 44 cycles; done on cycle 44 only.
- Back-to-back: valid held high with 0x55 then 0xAA -> two complete frames with exactly one idle-high cycle between them. A change to data mid-frame does not alter the frame in flight.
- Assert rst_n=0 during bit 3 of the data -> tx=1 within the same cycle, no done pulse. ready=1 after release; the next frame is sent correctly.
